// File: rtl/fft_stream_pkg.sv
// Shared types and default sizes for the per-bin spectral stream blocks.
package fft_stream_pkg;

    localparam int DEF_WIDTH  = 21;
    localparam int DEF_LGSIZE = 9;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] re;
        logic [DEF_WIDTH-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        WR_WAIT,
        WR_FILL,
        WR_DROP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_e;

endpackage

// File: rtl/bin_bank_ram.sv
// Two frame banks in one simple dual-port RAM; the address MSB selects the bank.
// The read port only updates when re is high, so a stalled consumer sees stable data.
module bin_bank_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 42
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [0:(1<<ADDR_W)-1];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_reg[raddr];
        end
    end

endmodule

// File: rtl/fft_bin_frame_collector.sv
// Collects 2^LGSIZE-bin frames into a ping-pong buffer and replays them over valid/ready.
// Optional FRAME_CHECK_EN adds o_frame_err and a saturating o_err_count.
module fft_bin_frame_collector
    import fft_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LGSIZE = DEF_LGSIZE
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic [2*WIDTH-1:0] i_sample,
    input  logic               i_sync,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_first,
    output logic               o_last,
`ifdef FRAME_CHECK_EN
    output logic               o_frame_err,
    output logic [15:0]        o_err_count,
`endif
    output logic               o_overflow
);

    localparam int AW = LGSIZE + 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [LGSIZE-1:0] LAST_IDX = {LGSIZE{1'b1}};
    localparam logic [LGSIZE-1:0] ONE_IDX  = LGSIZE'(1);

    // Write side
    wr_state_e         wr_state_reg, wr_state_next;
    logic [LGSIZE-1:0] wr_idx_reg, wr_idx_next;
    logic              wr_bank_reg, wr_bank_next;
    logic              drop_armed_reg, drop_armed_next;
    logic [1:0]        full_reg, full_next;
    logic [1:0]        bank_done, bank_freed;
    logic              overflow_reg, overflow_next;
    logic              frame_err_next;
    logic              wr_free;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;

    // Read side
    rd_state_e         rd_state_reg, rd_state_next;
    logic [LGSIZE-1:0] rd_idx_reg, rd_idx_next;
    logic              rd_bank_reg, rd_bank_next;
    logic              free_bank_reg;
    logic              ram_re, rd_first, rd_last;
    logic [AW-1:0]     ram_raddr;
    logic [DW-1:0]     ram_rdata;
    logic              s1_valid_reg, s1_first_reg, s1_last_reg;
    logic              out_valid_reg, out_first_reg, out_last_reg;
    logic [DW-1:0]     out_data_reg;
    logic              out_fire, out_ready, s1_adv, s1_room, freeing;

    assign out_fire  = out_valid_reg && i_ready;
    assign out_ready = !out_valid_reg || i_ready;
    assign s1_adv    = s1_valid_reg && out_ready;
    assign s1_room   = !s1_valid_reg || out_ready;
    assign freeing   = out_fire && out_last_reg;

    // A bank released this cycle already counts as free for an arriving bin 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_freed[gi] = freeing && (free_bank_reg == 1'(gi));
        end
    endgenerate

    assign wr_free   = !full_reg[wr_bank_reg] || bank_freed[wr_bank_reg];
    assign full_next = (full_reg & ~bank_freed) | bank_done;

    always_comb begin
        wr_state_next   = wr_state_reg;
        wr_idx_next     = wr_idx_reg;
        wr_bank_next    = wr_bank_reg;
        drop_armed_next = drop_armed_reg;
        bank_done       = 2'b00;
        overflow_next   = 1'b0;
        frame_err_next  = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = {wr_bank_reg, wr_idx_reg};
        if (i_ce) begin
            case (wr_state_reg)
                WR_WAIT, WR_DROP: begin
                    if (i_sync) begin
                        wr_idx_next = ONE_IDX;
                        if (wr_free) begin
                            ram_we          = 1'b1;
                            ram_waddr       = {wr_bank_reg, {LGSIZE{1'b0}}};
                            wr_state_next   = WR_FILL;
                            drop_armed_next = 1'b0;
                        end else begin
                            wr_state_next   = WR_DROP;
                            drop_armed_next = 1'b1;
                        end
                    end else if (wr_state_reg == WR_DROP && drop_armed_reg) begin
                        wr_idx_next = wr_idx_reg + ONE_IDX;
                        if (wr_idx_reg == LAST_IDX) begin
                            overflow_next   = 1'b1;
                            drop_armed_next = 1'b0;
                        end
                    end
                end
                WR_FILL: begin
                    ram_we = 1'b1;
                    if (i_sync) begin
                        ram_waddr      = {wr_bank_reg, {LGSIZE{1'b0}}};
                        wr_idx_next    = ONE_IDX;
                        frame_err_next = 1'b1;
                    end else begin
                        wr_idx_next = wr_idx_reg + ONE_IDX;
                        if (wr_idx_reg == LAST_IDX) begin
                            bank_done[wr_bank_reg] = 1'b1;
                            wr_bank_next           = ~wr_bank_reg;
                            wr_state_next          = WR_WAIT;
                        end
                    end
                end
                default: wr_state_next = WR_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_state_reg   <= WR_WAIT;
            wr_idx_reg     <= '0;
            wr_bank_reg    <= 1'b0;
            drop_armed_reg <= 1'b0;
            full_reg       <= 2'b00;
            overflow_reg   <= 1'b0;
        end else begin
            wr_state_reg   <= wr_state_next;
            wr_idx_reg     <= wr_idx_next;
            wr_bank_reg    <= wr_bank_next;
            drop_armed_reg <= drop_armed_next;
            full_reg       <= full_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Reads run ahead of the consumer, so the next bank starts without a bubble.
    always_comb begin
        rd_state_next = rd_state_reg;
        rd_idx_next   = rd_idx_reg;
        rd_bank_next  = rd_bank_reg;
        ram_re        = 1'b0;
        rd_first      = 1'b0;
        rd_last       = 1'b0;
        case (rd_state_reg)
            RD_IDLE: begin
                if (full_reg[rd_bank_reg] && s1_room) begin
                    ram_re        = 1'b1;
                    rd_state_next = RD_STREAM;
                end
            end
            RD_STREAM: ram_re = s1_room;
            default:   rd_state_next = RD_IDLE;
        endcase
        if (ram_re) begin
            rd_first    = (rd_idx_reg == '0);
            rd_last     = (rd_idx_reg == LAST_IDX);
            rd_idx_next = rd_idx_reg + ONE_IDX;
            if (rd_last) begin
                rd_bank_next  = ~rd_bank_reg;
                rd_state_next = RD_IDLE;
            end
        end
    end

    assign ram_raddr = {rd_bank_reg, rd_idx_reg};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_state_reg  <= RD_IDLE;
            rd_idx_reg    <= '0;
            rd_bank_reg   <= 1'b0;
            free_bank_reg <= 1'b0;
            s1_valid_reg  <= 1'b0;
            s1_first_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_first_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            rd_state_reg <= rd_state_next;
            rd_idx_reg   <= rd_idx_next;
            rd_bank_reg  <= rd_bank_next;
            if (freeing) begin
                free_bank_reg <= ~free_bank_reg;
            end
            if (ram_re) begin
                s1_valid_reg <= 1'b1;
                s1_first_reg <= rd_first;
                s1_last_reg  <= rd_last;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
            if (s1_adv) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= ram_rdata;
                out_first_reg <= s1_first_reg;
                out_last_reg  <= s1_last_reg;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    bin_bank_ram #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) u_ram (
        .i_clk (i_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (i_sample),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign o_valid    = out_valid_reg;
    assign o_data     = out_data_reg;
    assign o_first    = out_first_reg;
    assign o_last     = out_last_reg;
    assign o_overflow = overflow_reg;

`ifdef FRAME_CHECK_EN
    logic        frame_err_reg;
    logic [15:0] err_count_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_err_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            frame_err_reg <= frame_err_next;
            // Resync and overflow can never coincide, so one step per cycle suffices.
            if ((frame_err_next || overflow_next) && err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign o_frame_err = frame_err_reg;
    assign o_err_count = err_count_reg;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_next;
`endif

endmodule

// File: tb/tb_fft_bin_frame_collector.sv
// Scoreboard bench for fft_bin_frame_collector with LGSIZE=3, WIDTH=21.
module tb_fft_bin_frame_collector;
    import fft_stream_pkg::*;

    localparam int WIDTH  = 21;
    localparam int LGSIZE = 3;
    localparam int N      = 1 << LGSIZE;

    logic               clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_ce = 1'b0;
    logic [2*WIDTH-1:0] i_sample = '0;
    logic               i_sync = 1'b0;
    logic               i_ready = 1'b1;
    logic               o_valid, o_first, o_last, o_overflow;
    logic [2*WIDTH-1:0] o_data;
`ifdef FRAME_CHECK_EN
    logic               o_frame_err;
    logic [15:0]        o_err_count;
`endif

    always #5 clk = ~clk;

    fft_bin_frame_collector #(.WIDTH(WIDTH), .LGSIZE(LGSIZE)) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_sample   (i_sample),
        .i_sync     (i_sync),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_first    (o_first),
        .o_last     (o_last),
`ifdef FRAME_CHECK_EN
        .o_frame_err(o_frame_err),
        .o_err_count(o_err_count),
`endif
        .o_overflow (o_overflow)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_beat;
    int          pop_count = 0;
    int          ovf_seen = 0;
    int          ferr_seen = 0;
    int          cyc = 0;
    int          last_pop_cyc = -10;
    int          run_len = 0;
    int          max_run = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] mk_sample(input int v);
        sample_t s;
        s.re = WIDTH'(v);
        s.im = ~s.re;
        return s;
    endfunction

    function automatic logic [63:0] mk_beat(input int base, input int k);
        logic [63:0] b;
        b = {20'd0, (k == 0), (k == N-1), mk_sample(base + k)};
        return b;
    endfunction

    // Beats are popped at the negedge preceding the handshake edge.
    always @(negedge clk) begin
        cyc++;
        if (o_overflow) ovf_seen++;
`ifdef FRAME_CHECK_EN
        if (o_frame_err) ferr_seen++;
`endif
        if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {20'd0, o_first, o_last, o_data}, 64'hDEAD);
            end else begin
                exp_beat = sb_q.pop_front();
                chk("beat", {20'd0, o_first, o_last, o_data}, exp_beat);
            end
            pop_count++;
            run_len = (cyc == last_pop_cyc + 1) ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
            last_pop_cyc = cyc;
        end else if (o_valid && sb_q.size() != 0) begin
            chk("stall_hold", {20'd0, o_first, o_last, o_data}, sb_q[0]);
        end
    end

    task automatic drive_bin(input int v, input bit sync);
        i_ce = 1'b1;
        i_sync = sync;
        i_sample = mk_sample(v);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int base, input bit accept, input bit exp_ovf);
        if (accept) begin
            for (int k = 0; k < N; k++) sb_q.push_back(mk_beat(base, k));
        end
        for (int k = 0; k < N; k++) drive_bin(base + k, k == 0);
        i_ce = 1'b0;
        i_sync = 1'b0;
        chk("overflow_at_bin_last", {63'd0, o_overflow}, {63'd0, exp_ovf});
    endtask

    task automatic wait_drain(input bit toggle);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || o_valid) && n < 300) begin
            @(posedge clk); #1;
            if (toggle) i_ready = ~i_ready;
            n++;
        end
        i_ready = 1'b1;
        chk("drain_in_time", {63'd0, n < 300}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, ovf_mark;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_data", {22'd0, o_data}, 64'd0);
        chk("rst_first_last", {62'd0, o_first, o_last}, 64'd0);
        chk("rst_overflow", {63'd0, o_overflow}, 64'd0);
        i_reset_n = 1'b1;
        @(posedge clk); #1;

        // Single frame, latency from bin N-1 write.
        send_frame(16'h000, 1'b1, 1'b0);
        @(negedge clk); chk("lat_cycle1", {63'd0, o_valid}, 64'd0);
        @(negedge clk); chk("lat_cycle2", {63'd0, o_valid}, 64'd0);
        @(negedge clk); chk("lat_cycle3", {63'd0, o_valid}, 64'd1);
        @(posedge clk); #1;
        wait_drain(1'b0);

        // Two back-to-back frames stream without a gap.
        max_run = 0;
        ovf_mark = ovf_seen;
        send_frame(16'h040, 1'b1, 1'b0);
        send_frame(16'h080, 1'b1, 1'b0);
        wait_drain(1'b0);
        chk("b2b_run", 64'(max_run), 64'd16);
        chk("b2b_no_ovf", 64'(ovf_seen - ovf_mark), 64'd0);

        // Consumer alternates ready.
        send_frame(16'h0C0, 1'b1, 1'b0);
        wait_drain(1'b1);

        // Stalled consumer: two frames buffered, third dropped.
        i_ready = 1'b0;
        mark = pop_count;
        ovf_mark = ovf_seen;
        send_frame(16'h100, 1'b1, 1'b0);
        send_frame(16'h140, 1'b1, 1'b0);
        send_frame(16'h180, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_nothing_popped", 64'(pop_count - mark), 64'd0);
        chk("hold_valid", {63'd0, o_valid}, 64'd1);
        i_ready = 1'b1;
        wait_drain(1'b0);
        chk("hold_beats", 64'(pop_count - mark), 64'd16);
        chk("hold_ovf_pulses", 64'(ovf_seen - ovf_mark), 64'd1);

        // Reset while beat 3 is being presented.
        mark = pop_count;
        send_frame(16'h1C0, 1'b1, 1'b0);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (pop_count >= mark + 3) break;
        end
        chk("beat3_reached", 64'(pop_count - mark), 64'd3);
        #1;
        i_reset_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, o_valid}, 64'd0);
        chk("midrst_data", {22'd0, o_data}, 64'd0);
        chk("midrst_first_last", {62'd0, o_first, o_last}, 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        mark = pop_count;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_beats", 64'(pop_count - mark), 64'd0);
        chk("post_rst_valid", {63'd0, o_valid}, 64'd0);

        // Resync at bin 4: the partial frame is discarded.
        mark = pop_count;
        ovf_mark = ferr_seen;
        for (int k = 0; k < 4; k++) drive_bin(16'h200 + k, k == 0);
        send_frame(16'h240, 1'b1, 1'b0);
        wait_drain(1'b0);
        chk("resync_beats", 64'(pop_count - mark), 64'd8);
`ifdef FRAME_CHECK_EN
        chk("resync_frame_err", 64'(ferr_seen - ovf_mark), 64'd1);
        chk("resync_err_count", {48'd0, o_err_count}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
